// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into the I/S/B/U/J immediate fields of a
// RISC-V instruction word, merged with the caller's non-immediate fields.
// Two-stage valid/ready pipeline: S1 holds the request, S2 holds the assembled word.
// Optional feature macro: RANGE_CHECK_EN (adds out_err range flag; otherwise out_err = 0).

`ifndef I_TYPE
`define NULL_TYPE 3'd0
`define I_TYPE    3'd1
`define S_TYPE    3'd2
`define B_TYPE    3'd3
`define U_TYPE    3'd4
`define J_TYPE    3'd5
`endif

module imm_encoder #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PASS_UNKNOWN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_itype,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        s1_v;
    logic [2:0]  s1_itype;
    logic [31:0] s1_base;
    logic [31:0] s1_imm;
    logic        s2_v;
    logic        s2_free_c;
    logic        s1_free_c;
    logic [31:0] asm_c;

    // Stage occupancy: S2 frees when empty or draining; S1 frees when empty or moving to S2
    always_comb begin
        s2_free_c = !s2_v || out_ready;
        s1_free_c = !s1_v || s2_free_c;
    end

    assign in_ready  = s1_free_c;
    assign out_valid = s2_v;

    // S1: capture the request whenever the stage is free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_itype <= 3'd0;
            s1_base  <= 32'd0;
            s1_imm   <= 32'd0;
        end else if (s1_free_c) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_itype <= in_itype;
                s1_base  <= in_base;
                s1_imm   <= in_imm;
            end
        end
    end

    // Assemble the instruction: immediate fields replace the base's bits, the rest pass through
    always_comb begin
        asm_c = s1_base;
        case (s1_itype)
            `I_TYPE: asm_c = {s1_imm[11:0], s1_base[19:0]};
            `S_TYPE: asm_c = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
            `B_TYPE: asm_c = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                              s1_imm[4:1], s1_imm[11], s1_base[6:0]};
            `U_TYPE: asm_c = {s1_imm[31:12], s1_base[11:0]};
            `J_TYPE: asm_c = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                              s1_imm[19:12], s1_base[11:0]};
            default: asm_c = (PASS_UNKNOWN != 0) ? s1_base : NOP_INST;
        endcase
    end

    // S2: load from S1 whenever S2 is empty or being drained (collapses bubbles)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            out_inst <= 32'd0;
        end else if (s2_free_c) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_inst <= asm_c;
            end
        end
    end

    // Completed output handshakes, wrapping at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (s2_v && out_ready) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

`ifdef RANGE_CHECK_EN
    logic range_c;
    logic s1_err;

    // Flag immediates whose value cannot be reproduced by decoding the chosen format
    always_comb begin
        range_c = 1'b0;
        case (in_itype)
            `I_TYPE, `S_TYPE: range_c = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            `B_TYPE:          range_c = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            `U_TYPE:          range_c = |in_imm[11:0];
            `J_TYPE:          range_c = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            default:          range_c = 1'b0;
        endcase
    end

    // Range flag travels alongside the request through both stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err  <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (s1_free_c && in_valid) begin
                s1_err <= range_c;
            end
            if (s2_free_c && s1_v) begin
                out_err <= s1_err;
            end
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed spec cases, backpressure, async reset
// mid-stream and a randomized round-trip stream against a bit-map reference model.

`ifndef I_TYPE
`define NULL_TYPE 3'd0
`define I_TYPE    3'd1
`define S_TYPE    3'd2
`define B_TYPE    3'd3
`define U_TYPE    3'd4
`define J_TYPE    3'd5
`endif

module tb_imm_encoder;

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned PASS_UNKNOWN = 1;
`ifdef RANGE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_itype;
    logic [31:0]      in_base;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] out_count;

    imm_encoder #(.CNT_W(CNT_W), .PASS_UNKNOWN(PASS_UNKNOWN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_itype  (in_itype),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] base;
        logic [31:0] imm;
    } req_t;

    req_t        stim_q[$];
    logic [31:0] exp_inst_q[$];
    logic        exp_err_q[$];
    logic        exp_rt_q[$];
    logic [2:0]  exp_t_q[$];
    logic [31:0] exp_imm_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit known_type(input logic [2:0] t);
        return t == `I_TYPE || t == `S_TYPE || t == `B_TYPE || t == `U_TYPE || t == `J_TYPE;
    endfunction

    // Which immediate bit lands at instruction bit pos (-1: not an immediate field)
    function automatic int src_bit(input logic [2:0] t, input int pos);
        case (t)
            `I_TYPE: return (pos >= 20) ? pos - 20 : -1;
            `S_TYPE: begin
                if (pos >= 25) return pos - 20;
                if (pos >= 7 && pos <= 11) return pos - 7;
                return -1;
            end
            `B_TYPE: begin
                if (pos == 31) return 12;
                if (pos >= 25) return pos - 20;
                if (pos >= 8 && pos <= 11) return pos - 7;
                if (pos == 7) return 11;
                return -1;
            end
            `U_TYPE: return (pos >= 12) ? pos : -1;
            `J_TYPE: begin
                if (pos == 31) return 20;
                if (pos >= 21) return pos - 20;
                if (pos == 20) return 11;
                if (pos >= 12) return pos;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] model_encode(input logic [2:0] t, input logic [31:0] base,
                                                 input logic [31:0] imm);
        logic [31:0] r;
        int s;
        if (!known_type(t)) return (PASS_UNKNOWN != 0) ? base : 32'h0000_0013;
        for (int p = 0; p < 32; p++) begin
            s = src_bit(t, p);
            r[p] = (s < 0) ? base[p] : imm[s];
        end
        return r;
    endfunction

    // True when the value survives an encode/decode round trip
    function automatic bit in_range(input logic [2:0] t, input logic [31:0] imm);
        longint v;
        v = longint'($signed(imm));
        case (t)
            `I_TYPE, `S_TYPE: return v >= -2048 && v <= 2047;
            `B_TYPE: return v >= -4096 && v <= 4095 && (v % 2) == 0;
            `U_TYPE: return (imm % 4096) == 0;
            `J_TYPE: return v >= -(64'sd1 << 20) && v < (64'sd1 << 20) && (v % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    // Decode-side immediate generator
    function automatic logic [31:0] decode_imm(input logic [2:0] t, input logic [31:0] i);
        case (t)
            `I_TYPE: return {{20{i[31]}}, i[31:20]};
            `S_TYPE: return {{20{i[31]}}, i[31:25], i[11:7]};
            `B_TYPE: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            `U_TYPE: return {i[31:12], 12'd0};
            `J_TYPE: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_imm(input logic [2:0] t);
        if ($urandom_range(0, 9) == 0) return $urandom;
        case (t)
            `I_TYPE, `S_TYPE: return 32'($signed($urandom_range(0, 4095)) - 2048);
            `B_TYPE: return 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
            `U_TYPE: return $urandom & 32'hFFFF_F000;
            `J_TYPE: return 32'(($signed($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_queues();
        stim_q.delete(); exp_inst_q.delete(); exp_err_q.delete();
        exp_rt_q.delete(); exp_t_q.delete(); exp_imm_q.delete();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        clear_queues();
    endtask

    // Single request with out_ready=1: checks the two-edge latency and the word produced
    task automatic directed(input string tag, input logic [2:0] t, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] exp_inst, input logic exp_err);
        @(negedge clk);
        in_valid = 1'b1; in_itype = t; in_base = b; in_imm = im; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_base = $urandom; in_imm = $urandom;
        @(negedge clk);
        check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        exp_count++;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_count"}, 32'(out_count), 32'(exp_count));
    endtask

    // Drive stim_q through the DUT; mode 0 random valid/ready, mode 1 back-to-back with ready 1,0,0,1
    task automatic run_stream(input int mode, input int budget);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] held_inst = '0;
        logic        held_err = 1'b0;
        int          pat[4] = '{1, 0, 0, 1};
        req_t        r;
        while ((stim_q.size() > 0 || exp_inst_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_inst", out_inst, held_inst);
                check("hold_err", 32'(out_err), 32'(held_err));
            end
            in_valid = (stim_q.size() > 0) && (mode == 1 || $urandom_range(0, 3) != 0);
            if (in_valid) begin
                r = stim_q[0];
                in_itype = r.t; in_base = r.base; in_imm = r.imm;
            end else begin
                in_itype = 3'($urandom); in_base = $urandom; in_imm = $urandom;
            end
            out_ready = (mode == 1) ? (pat[cyc % 4] != 0) : ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                r = stim_q.pop_front();
                exp_inst_q.push_back(model_encode(r.t, r.base, r.imm));
                exp_err_q.push_back(RC_EN && known_type(r.t) && !in_range(r.t, r.imm));
                exp_rt_q.push_back(known_type(r.t) && in_range(r.t, r.imm));
                exp_t_q.push_back(r.t);
                exp_imm_q.push_back(r.imm);
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_inst_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    logic [2:0]  t;
                    logic [31:0] im;
                    t  = exp_t_q.pop_front();
                    im = exp_imm_q.pop_front();
                    check("inst", out_inst, exp_inst_q.pop_front());
                    check("err", 32'(out_err), 32'(exp_err_q.pop_front()));
                    if (exp_rt_q.pop_front()) check("roundtrip", decode_imm(t, out_inst), im);
                    exp_count++;
                end
            end else if (out_valid) begin
                stalled = 1'b1; held_inst = out_inst; held_err = out_err;
            end
            cyc++;
        end
        check("stream_in_budget", 32'(cyc < budget), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("stream_count", 32'(out_count), 32'(exp_count));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_itype = 3'd0; in_base = 32'd0; in_imm = 32'd0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        directed("i_addi", `I_TYPE, 32'h0000_0513, 32'hFFFF_FFFF, 32'hFFF0_0513, 1'b0);
        directed("b_m4",   `B_TYPE, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        directed("b_4096", `B_TYPE, 32'h0000_0063, 32'd4096,      32'h8000_0063, RC_EN);
        directed("j_2048", `J_TYPE, 32'h0000_00EF, 32'd2048,      32'h0010_00EF, 1'b0);
        directed("u_lui",  `U_TYPE, 32'h0000_0537, 32'h1234_5000, 32'h1234_5537, 1'b0);
        directed("s_neg",  `S_TYPE, 32'h0000_2023, 32'hFFFF_F800, 32'h8000_2023, 1'b0);
        directed("null",   `NULL_TYPE, 32'hDEAD_BEEF, 32'h1234_5678,
                 (PASS_UNKNOWN != 0) ? 32'hDEAD_BEEF : 32'h0000_0013, 1'b0);

        // Five back-to-back requests under a 1,0,0,1 ready pattern from a clean count
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            req_t r;
            r.t = 3'($urandom_range(1, 5)); r.base = $urandom; r.imm = rand_imm(r.t);
            stim_q.push_back(r);
        end
        run_stream(1, 200);
        check("bp_count5", 32'(out_count), 32'd5);

        // Randomized stream, all format codes including unused ones
        for (int k = 0; k < 10000; k++) begin
            req_t r;
            r.t = 3'($urandom_range(0, 7)); r.base = $urandom; r.imm = rand_imm(r.t);
            stim_q.push_back(r);
        end
        run_stream(0, 60000);

        // Fill both stages, then assert reset between edges
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        in_itype = `I_TYPE; in_base = 32'h0000_0513; in_imm = 32'd5;
        @(posedge clk);
        @(negedge clk);
        in_imm = 32'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count_nonzero", 32'(out_count != 0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_count", 32'(out_count), 32'd0);
        check("arst_out_inst", out_inst, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        @(posedge clk);
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_no_stale", 32'(out_valid), 32'd0);
        directed("post_rst", `U_TYPE, 32'h0000_0037, 32'hABCD_E000, 32'hABCD_E037, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
